filter_bank_loader: RTL
=======================

# filter_bank_loader

Loads 3x3x3 convolution filter coefficients from a serial valid/ready stream into four register banks (Filter1..Filter4). The banks feed the convolution engine's filter selection mux. One bank is written per load transaction. Per-bank valid flags tell the engine which filters are usable.

## Interface
- WIDTH, 8, coefficient width in bits
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle request to begin loading a bank; sampled only in IDLE
- load_sel  in  2  target bank (0..3 -> Filter1..Filter4); captured with load_start
- s_valid  in  1  coefficient stream valid
- s_ready  out  1  coefficient stream ready
- s_data  in  WIDTH  coefficient
- s_last  in  1  marks the final (27th) coefficient of a filter
- Filter1..Filter4  out  WIDTH x [2:0][2:0][2:0]  coefficient banks, indexed [row][column][channel]
- bank_valid  out  4  bit n = bank n fully loaded
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse when a load completes
- err  out  1  sticky framing error (only with check compiled in)

## Operation
- The FSM has three states: IDLE, LOAD and DONE.
- **IDLE**
  - s_ready=0.
  - When load_start=1: latch load_sel into sel, clear bank_valid[sel], clear err, and go to LOAD.
- **LOAD**
  - s_ready=1.
  - A beat is accepted when s_valid && s_ready.
  - Each accepted beat writes s_data to bank sel at [i][j][k].
  - A 5-bit beat counter runs 0..26.
  - Coefficient order: channel k outermost, then row i, then column j innermost.
    - Beat n maps to k=n/9, i=(n%9)/3, j=n%3.
  - When beat 26 is accepted: go to DONE.
- **DONE**
  - s_ready=0, done=1, bank_valid[sel]=1.
  - Next state is unconditionally IDLE.
- Banks other than sel are never modified and stay readable throughout.
- The bank being loaded updates beat by beat while its bank_valid is 0.
- load_start outside IDLE is ignored; load_sel is not re-sampled.
- The beat counter resets to 0 on every entry into LOAD.
- Reloading an already-valid bank is allowed. Its bank_valid drops when the load starts.
- Reset (asynchronous, any state) sets:
  - state=IDLE;
  - all 108 coefficients=0;
  - bank_valid=4'b0000, s_ready=0, busy=0, done=0, err=0;
  - beat counter=0.

## Timing
- load_start is sampled at edge T. s_ready=1 from cycle T+1.
- The accepted beat at edge E is visible on the Filter outputs from cycle E+1.
- The final beat is accepted at edge F:
  - done=1 and bank_valid[sel]=1 during cycle F+1;
  - IDLE from F+2.
- A new load_start can be issued in cycle F+2.
- Minimum load is 29 cycles (1 + 27 + 1) with s_valid held high.
- s_valid gaps stall the counter. There is no timeout.
- All outputs are registered. There is no combinational path from s_valid to s_ready.

## Configuration
- Macro: FILTER_LOADER_LAST_CHECK_EN.
- **Defined:** s_last is checked on every accepted beat.
  - A mismatch is s_last=1 on beats 0..25, or s_last=0 on beat 26.
  - On a mismatch:
    - the mismatching beat is not written;
    - err is set;
    - the FSM returns directly to IDLE (no DONE, no done pulse);
    - bank_valid[sel] stays 0.
  - err holds until the next accepted load_start or reset.
- **Undefined:** s_last is ignored and err is tied to 0. Completion is by beat count only.

## Test plan
- Reset, then load bank 2 with data 1..27 and s_valid held high:
  - Filter3[0][0][0]=1, Filter3[2][2][0]=9, Filter3[0][0][1]=10, Filter3[2][2][2]=27;
  - done pulses exactly once, 28 cycles after load_start;
  - bank_valid=4'b0100;
  - Filter1, Filter2 and Filter4 stay all 0.
- Load bank 0 with s_valid toggling every other cycle (data 0xA0+n):
  - all 27 beats are captured in order;
  - completion is at 55 cycles;
  - no beats are lost or duplicated.
- Load bank 1 with 0x11, then pulse load_start with load_sel=3 mid-load:
  - the pulse is ignored;
  - only Filter2 changes;
  - bank_valid[3] stays 0.
- Reload valid bank 0:
  - bank_valid[0]=0 from the cycle after load_start until DONE;
  - old values are replaced beat by beat.
- Assert rst_n low after 10 beats into bank 3:
  - immediately all banks=0, bank_valid=0, s_ready=0;
  - after release, the FSM is in IDLE.
- With FILTER_LOADER_LAST_CHECK_EN, send s_last=1 on beat 5 into bank 1:
  - err=1, no done pulse, bank_valid[1]=0, FSM back in IDLE;
  - the next load_start clears err.

Source files
------------

// File: rtl/filter_bank_loader.sv
// filter_bank_loader
// Streams 27 coefficients (channel outermost, then row, then column) into one
// of four 3x3x3 filter banks selected at load start. Optional s_last framing
// check is compiled in with the macro FILTER_LOADER_LAST_CHECK_EN.
module filter_bank_loader #(
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               load_start,
  input  logic [1:0]                         load_sel,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [WIDTH-1:0]                   s_data,
  input  logic                               s_last,
  output logic [2:0][2:0][2:0][WIDTH-1:0]    Filter1,
  output logic [2:0][2:0][2:0][WIDTH-1:0]    Filter2,
  output logic [2:0][2:0][2:0][WIDTH-1:0]    Filter3,
  output logic [2:0][2:0][2:0][WIDTH-1:0]    Filter4,
  output logic [3:0]                         bank_valid,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_r, state_s;

  logic [3:0][2:0][2:0][2:0][WIDTH-1:0] bank_r;
  logic [1:0] sel_r;
  logic [4:0] beat_r;
  logic [1:0] i_r, j_r, k_r;
  logic       s_ready_r, busy_r, done_r, err_r;
  logic [3:0] bank_valid_r;

  logic accept_s, last_beat_s, frame_err_s, write_s, start_s;

  assign start_s     = (state_r == IDLE) && load_start;
  // s_ready_r is only ever high in LOAD, so the handshake implies LOAD.
  assign accept_s    = s_valid && s_ready_r;
  assign last_beat_s = (beat_r == 5'd26);

`ifdef FILTER_LOADER_LAST_CHECK_EN
  assign frame_err_s = accept_s && (s_last != last_beat_s);
`else
  // s_last plays no role when framing is not checked.
  logic unused_last_s;
  assign unused_last_s = s_last;
  assign frame_err_s   = 1'b0;
`endif

  // A mismatching beat is dropped rather than written.
  assign write_s = accept_s && !frame_err_s;

  assign Filter1    = bank_r[0];
  assign Filter2    = bank_r[1];
  assign Filter3    = bank_r[2];
  assign Filter4    = bank_r[3];
  assign bank_valid = bank_valid_r;
  assign s_ready    = s_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

  // Next-state logic for the IDLE/LOAD/DONE sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start) state_s = LOAD;
        else            state_s = IDLE;
      end
      LOAD: begin
        if (frame_err_s)                  state_s = IDLE;
        else if (accept_s && last_beat_s) state_s = DONE;
        else                              state_s = LOAD;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      s_ready_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      s_ready_r <= (state_s == LOAD);
      busy_r    <= (state_s == LOAD) || (state_s == DONE);
      done_r    <= (state_s == DONE);
    end
  end

  // Target bank capture and row/column/channel beat position tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r  <= 2'd0;
      beat_r <= 5'd0;
      i_r    <= 2'd0;
      j_r    <= 2'd0;
      k_r    <= 2'd0;
    end else if (start_s) begin
      sel_r  <= load_sel;
      beat_r <= 5'd0;
      i_r    <= 2'd0;
      j_r    <= 2'd0;
      k_r    <= 2'd0;
    end else if (write_s) begin
      beat_r <= beat_r + 5'd1;
      if (j_r == 2'd2) begin
        j_r <= 2'd0;
        if (i_r == 2'd2) begin
          i_r <= 2'd0;
          k_r <= k_r + 2'd1;
        end else begin
          i_r <= i_r + 2'd1;
        end
      end else begin
        j_r <= j_r + 2'd1;
      end
    end
  end

  // Coefficient storage: only the selected bank is written, one beat at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_r <= '0;
    end else if (write_s) begin
      bank_r[sel_r][i_r][j_r][k_r] <= s_data;
    end
  end

  // Bank valid flags: dropped when a load of that bank starts, set on its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_valid_r <= 4'b0000;
    end else if (start_s) begin
      bank_valid_r[load_sel] <= 1'b0;
    end else if (write_s && last_beat_s) begin
      bank_valid_r[sel_r] <= 1'b1;
    end
  end

  // Sticky framing error, cleared by the next accepted load request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (start_s) begin
      err_r <= 1'b0;
    end else if (frame_err_s) begin
      err_r <= 1'b1;
    end
  end

endmodule
